// File: rtl/writeback_scoreboard_pkg.sv
// writeback_scoreboard_pkg: shared types for the writeback merge and busy scoreboard.
package writeback_scoreboard_pkg;
  localparam int WB_XLEN = 32;
  localparam int NREGS = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic valid;
    logic [4:0] waddr;
    logic [WB_XLEN-1:0] wdata;
  } writeback_alu_in_type;

  typedef struct packed {
    logic issue;
    logic [4:0] issue_waddr;
    logic valid;
    logic [4:0] waddr;
    logic [WB_XLEN-1:0] wdata;
  } writeback_long_in_type;

  typedef struct packed {
    logic rden1;
    logic [4:0] raddr1;
    logic rden2;
    logic [4:0] raddr2;
    logic wren;
    logic [4:0] waddr;
    logic is_long;
  } writeback_dec_in_type;

  typedef struct packed {
    logic wren;
    logic [4:0] waddr;
    logic [WB_XLEN-1:0] wdata;
  } forwarding_exe_in_type;

  typedef struct packed {
    logic long_ready;
    logic stall;
    forwarding_exe_in_type exe;
    logic [NREGS-1:0] busy;
  } writeback_out_type;

  // x0 is hardwired, so it never becomes busy
  function automatic logic [NREGS-1:0] reg_mask(input logic en, input logic [4:0] addr);
    reg_mask = '0;
    if (en && addr != REG_X0) reg_mask[addr] = 1'b1;
  endfunction
endpackage

// File: rtl/writeback_scoreboard_bits.sv
// scoreboard_bits: per-register busy bits plus an outstanding multi-cycle op counter.
module scoreboard_bits
  import writeback_scoreboard_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [4:0]       set_addr,
  input  logic             clr_en,
  input  logic [4:0]       clr_addr,
  output logic [NREGS-1:0] busy,
  output logic             full
);
  localparam int CW = $clog2(MAX_PENDING + 1);
  logic [CW-1:0] count;
  logic inc, dec;
  assign full = count == CW'(MAX_PENDING);
  assign dec = clr_en && clr_addr != REG_X0 && count != '0;
  assign inc = set_en && set_addr != REG_X0 && (!full || dec);
  // set is ORed in after the clear so an issue beats a completion to the same register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      count <= '0;
    end else begin
      busy <= (busy & ~reg_mask(clr_en, clr_addr)) | reg_mask(set_en, set_addr);
      count <= count + CW'(inc) - CW'(dec);
    end
  end
endmodule

// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard: merges ALU and multi-cycle results onto one registered write port
// and stalls decode on hazards against still-pending multi-cycle destinations.
module writeback_scoreboard
  import writeback_scoreboard_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int MAX_PENDING = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_waddr,
  input  logic [XLEN-1:0] alu_wdata,
  input  logic            long_issue,
  input  logic [4:0]      long_issue_waddr,
  input  logic            long_valid,
  output logic            long_ready,
  input  logic [4:0]      long_waddr,
  input  logic [XLEN-1:0] long_wdata,
  input  logic            dec_rden1,
  input  logic [4:0]      dec_raddr1,
  input  logic            dec_rden2,
  input  logic [4:0]      dec_raddr2,
  input  logic            dec_wren,
  input  logic [4:0]      dec_waddr,
  input  logic            dec_long,
  output logic            stall,
  output logic            execute_wren,
  output logic [4:0]      execute_waddr,
  output logic [XLEN-1:0] execute_wdata,
  output logic [31:0]     busy
);
  writeback_alu_in_type alu;
  writeback_long_in_type lng;
  writeback_dec_in_type dec;
  writeback_out_type o;
  forwarding_exe_in_type exe_q, exe_d;
  logic [NREGS-1:0] busy_vec;
  logic full, xfer;
  assign alu = '{valid: alu_valid, waddr: alu_waddr, wdata: alu_wdata};
  assign lng = '{issue: long_issue, issue_waddr: long_issue_waddr, valid: long_valid,
                 waddr: long_waddr, wdata: long_wdata};
  assign dec = '{rden1: dec_rden1, raddr1: dec_raddr1, rden2: dec_rden2, raddr2: dec_raddr2,
                 wren: dec_wren, waddr: dec_waddr, is_long: dec_long};
  // ALU has fixed priority; the long unit waits while an ALU result is present
  assign xfer = lng.valid && !alu.valid;
  always_comb begin
    exe_d.wren = alu.valid ? alu.waddr != REG_X0 : xfer ? lng.waddr != REG_X0 : 1'b0;
    exe_d.waddr = alu.valid ? alu.waddr : xfer ? lng.waddr : exe_q.waddr;
    exe_d.wdata = alu.valid ? alu.wdata : xfer ? lng.wdata : exe_q.wdata;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) exe_q <= '0;
    else exe_q <= exe_d;
  end
  scoreboard_bits #(.MAX_PENDING(MAX_PENDING)) u_bits (
    .clock   (clock),
    .reset   (reset),
    .set_en  (lng.issue),
    .set_addr(lng.issue_waddr),
    .clr_en  (xfer),
    .clr_addr(lng.waddr),
    .busy    (busy_vec),
    .full    (full)
  );
  always_comb begin
    o.long_ready = !alu.valid;
    o.stall = (dec.rden1 && busy_vec[dec.raddr1]) || (dec.rden2 && busy_vec[dec.raddr2]) ||
              (dec.wren && busy_vec[dec.waddr]) || (dec.is_long && full);
    o.exe = exe_q;
    o.busy = busy_vec;
  end
  assign long_ready = o.long_ready;
  assign stall = o.stall;
  assign execute_wren = o.exe.wren;
  assign execute_waddr = o.exe.waddr;
  assign execute_wdata = o.exe.wdata;
  assign busy = o.busy;
  // an issue that coincides with a completion may reuse the freed slot or register
  a_long_not_busy: assert property (@(posedge clock) disable iff (!reset)
    !(long_valid && long_waddr != REG_X0 && !busy_vec[long_waddr]));
  a_alu_not_busy: assert property (@(posedge clock) disable iff (!reset)
    !(alu_valid && busy_vec[alu_waddr]));
  a_issue_not_full: assert property (@(posedge clock) disable iff (!reset)
    !(long_issue && long_issue_waddr != REG_X0 && full && !(xfer && long_waddr != REG_X0)));
  a_issue_not_busy: assert property (@(posedge clock) disable iff (!reset)
    !(long_issue && busy_vec[long_issue_waddr] && !(xfer && long_waddr == long_issue_waddr)));
endmodule

// File: tb/tb_writeback_scoreboard.sv
// tb_writeback_scoreboard: directed stimulus with a queue scoreboard on the write port.
module tb_writeback_scoreboard;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic alu_valid, long_issue, long_valid, long_ready;
  logic [4:0] alu_waddr, long_issue_waddr, long_waddr;
  logic [31:0] alu_wdata, long_wdata;
  logic dec_rden1, dec_rden2, dec_wren, dec_long, stall;
  logic [4:0] dec_raddr1, dec_raddr2, dec_waddr;
  logic execute_wren;
  logic [4:0] execute_waddr;
  logic [31:0] execute_wdata, busy;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [4:0] a;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  writeback_scoreboard dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .long_issue(long_issue), .long_issue_waddr(long_issue_waddr),
    .long_valid(long_valid), .long_ready(long_ready), .long_waddr(long_waddr), .long_wdata(long_wdata),
    .dec_rden1(dec_rden1), .dec_raddr1(dec_raddr1), .dec_rden2(dec_rden2), .dec_raddr2(dec_raddr2),
    .dec_wren(dec_wren), .dec_waddr(dec_waddr), .dec_long(dec_long), .stall(stall),
    .execute_wren(execute_wren), .execute_waddr(execute_waddr), .execute_wdata(execute_wdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    {alu_valid, long_issue, long_valid, dec_rden1, dec_rden2, dec_wren, dec_long} = '0;
    {alu_waddr, long_issue_waddr, long_waddr, dec_raddr1, dec_raddr2, dec_waddr} = '0;
    alu_wdata = '0;
    long_wdata = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (reset && execute_wren) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write", execute_waddr, execute_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (execute_waddr !== e.a || execute_wdata !== e.d) begin
          errors++;
          $display("FAIL write_port: got x%0d=%h expected x%0d=%h", execute_waddr, execute_wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wren", 32'(execute_wren), 0);
    chk("rst_waddr", 32'(execute_waddr), 0);
    chk("rst_wdata", execute_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", 32'(long_ready), 1);
    chk("rst_stall", 32'(stall), 0);
    reset = 1'b1;
    step();
    // ALU only
    alu_valid = 1; alu_waddr = 5; alu_wdata = 32'hDEADBEEF;
    #1 chk("alu_ready", 32'(long_ready), 0);
    push(5, 32'hDEADBEEF);
    step();
    chk("alu_wren", 32'(execute_wren), 1);
    chk("alu_busy", busy, 0);
    // Long RAW on x7
    long_issue = 1; long_issue_waddr = 7;
    step();
    chk("raw_busy", busy, 32'h80);
    for (int i = 0; i < 3; i++) begin
      dec_rden1 = 1; dec_raddr1 = 7;
      #1 chk("raw_stall", 32'(stall), 1);
      step();
    end
    long_valid = 1; long_waddr = 7; long_wdata = 32'h12; dec_rden1 = 1; dec_raddr1 = 7;
    #1 chk("raw_ready", 32'(long_ready), 1);
    chk("raw_stall_xfer", 32'(stall), 1);
    push(7, 32'h12);
    step();
    dec_rden1 = 1; dec_raddr1 = 7;
    #1 chk("raw_unstall", 32'(stall), 0);
    chk("raw_busy_clr", busy, 0);
    chk("raw_exe", {execute_wren, execute_waddr, execute_wdata[25:0]}, {1'b1, 5'd7, 26'h12});
    idle();
    // Collision: ALU x3 and long x9 together
    long_issue = 1; long_issue_waddr = 9;
    step();
    alu_valid = 1; alu_waddr = 3; alu_wdata = 32'h1;
    long_valid = 1; long_waddr = 9; long_wdata = 32'h2;
    #1 chk("col_ready0", 32'(long_ready), 0);
    push(3, 32'h1);
    step();
    chk("col_busy_hold", busy, 32'h200);
    long_valid = 1; long_waddr = 9; long_wdata = 32'h2;
    #1 chk("col_ready1", 32'(long_ready), 1);
    push(9, 32'h2);
    step();
    chk("col_busy", busy, 0);
    // Full: four outstanding ops
    for (int i = 1; i <= 4; i++) begin
      long_issue = 1; long_issue_waddr = 5'(i);
      step();
    end
    chk("full_busy", busy, 32'h1E);
    dec_long = 1;
    #1 chk("full_stall", 32'(stall), 1);
    long_issue = 1; long_issue_waddr = 5; long_valid = 1; long_waddr = 1; long_wdata = 32'h11;
    push(1, 32'h11);
    step();
    chk("full_swap_busy", busy, 32'h3C);
    dec_long = 1;
    #1 chk("full_swap_stall", 32'(stall), 1);
    long_valid = 1; long_waddr = 2; long_wdata = 32'h22;
    push(2, 32'h22);
    step();
    dec_long = 1;
    #1 chk("full_unstall", 32'(stall), 0);
    chk("full_busy2", busy, 32'h38);
    idle();
    for (int i = 3; i <= 5; i++) begin
      long_valid = 1; long_waddr = 5'(i); long_wdata = 32'(i * 16'h11);
      push(5'(i), 32'(i * 16'h11));
      step();
    end
    chk("drain_busy", busy, 0);
    // x0 and WAW
    long_issue = 1; long_issue_waddr = 0;
    step();
    chk("x0_busy", busy, 0);
    long_valid = 1; long_waddr = 0; long_wdata = 32'h55;
    #1 chk("x0_ready", 32'(long_ready), 1);
    step();
    chk("x0_wren", 32'(execute_wren), 0);
    long_issue = 1; long_issue_waddr = 4;
    step();
    dec_wren = 1; dec_waddr = 4;
    #1 chk("waw_stall", 32'(stall), 1);
    dec_waddr = 6;
    #1 chk("waw_free", 32'(stall), 0);
    dec_wren = 0; dec_rden2 = 1; dec_raddr2 = 4;
    #1 chk("raw2_stall", 32'(stall), 1);
    idle();
    // Async reset with two ops pending
    long_issue = 1; long_issue_waddr = 6;
    step();
    chk("pend_busy", busy, 32'h50);
    alu_valid = 1; alu_waddr = 8; alu_wdata = 32'h99;
    push(8, 32'h99);
    step();
    chk("pre_rst_wren", 32'(execute_wren), 1);
    #4;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wren", 32'(execute_wren), 0);
    chk("arst_wdata", execute_wdata, 0);
    reset = 1'b1;
    step();
    step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
